// File: rtl/sm4_tau_arbiter.sv
// sm4_tau_arbiter
//   Schedules the single SM4 byte S-box between two requesters (round datapath
//   "r_" and key-expansion datapath "k_"). A granted 32-bit word is substituted
//   one byte per cycle, MSB first, and returned with a one-cycle done pulse
//   for whichever requester owned it.
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   r_valid/r_word  : round request and word;   r_ready grant, r_done result pulse
//   k_valid/k_word  : key request and word;     k_ready grant, k_done result pulse
//   res_word        : most recent tau result, held until the next completion
//   busy            : a transaction is in SUB or DONE

// Byte S-box: pure lookup table of the SM4 substitution.
module sm4_sbox (
  input  logic [7:0] data_in,
  output logic [7:0] res_out
);

  localparam logic [7:0] SBOX_TABLE [0:255] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  assign res_out = SBOX_TABLE[data_in];

endmodule

module sm4_tau_arbiter #(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_valid,
  input  logic [31:0] r_word,
  output logic        r_ready,
  output logic        r_done,
  input  logic        k_valid,
  input  logic [31:0] k_word,
  output logic        k_ready,
  output logic        k_done,
  output logic [31:0] res_word,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic        r_ptr;
  logic        r_owner;
  logic [31:0] r_wreg;
  logic [31:0] r_acc;
  logic [31:0] r_resWord;
  logic        r_rDone;
  logic        r_kDone;

  logic        w_idle;
  logic        w_rGrant;
  logic        w_kGrant;
  logic [7:0]  w_sboxIn;
  logic [7:0]  w_sboxOut;

  sm4_sbox u_sbox (
    .data_in (w_sboxIn),
    .res_out (w_sboxOut)
  );

  // Grant only from IDLE and never while reset is asserted. When both ask,
  // r_ptr names the favoured requester (0 = round, 1 = key).
  assign w_idle   = (r_state == IDLE) && !rst;
  assign w_rGrant = w_idle && r_valid && (!k_valid || !r_ptr);
  assign w_kGrant = w_idle && k_valid && (!r_valid ||  r_ptr);

  // Feed the S-box the byte selected by the counter, MSB first; zero otherwise.
  always_comb begin
    w_sboxIn = 8'h00;
    if (r_state == SUB) begin
      case (r_cnt)
        2'd0:    w_sboxIn = r_wreg[31:24];
        2'd1:    w_sboxIn = r_wreg[23:16];
        2'd2:    w_sboxIn = r_wreg[15:8];
        default: w_sboxIn = r_wreg[7:0];
      endcase
    end
  end

  // Main FSM. The result register and done pulses are loaded on the last SUB
  // edge, so in DONE they present the accumulated word without extra logic.
  // The pointer always moves to the requester that was not just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 2'd0;
      r_ptr     <= PRIO_INIT;
      r_owner   <= 1'b0;
      r_wreg    <= 32'd0;
      r_acc     <= 32'd0;
      r_resWord <= 32'd0;
      r_rDone   <= 1'b0;
      r_kDone   <= 1'b0;
    end else begin
      r_rDone <= 1'b0;
      r_kDone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rGrant || w_kGrant) begin
            r_wreg  <= w_kGrant ? k_word : r_word;
            r_owner <= w_kGrant;
            r_ptr   <= w_rGrant;
            r_cnt   <= 2'd0;
            r_state <= SUB;
          end
        end
        SUB: begin
          r_acc <= {r_acc[23:0], w_sboxOut};
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_resWord <= {r_acc[23:0], w_sboxOut};
            r_rDone   <= !r_owner;
            r_kDone   <= r_owner;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign r_ready  = w_rGrant;
  assign k_ready  = w_kGrant;
  assign r_done   = r_rDone;
  assign k_done   = r_kDone;
  assign res_word = r_resWord;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_sm4_tau_arbiter.sv
// tb_sm4_tau_arbiter
//   Drives both requesters with directed and random words, keeps a
//   per-requester queue of expected tau results and completion cycles, and a
//   negedge monitor compares grants, busy, done pulses and res_word.
module tb_sm4_tau_arbiter;

  localparam bit PRIO_INIT = 1'b0;

  localparam logic [7:0] SM4_SBOX [0:255] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  typedef struct {
    logic [31:0] res;
    int          doneCyc;
  } expEntry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_valid, k_valid;
  logic [31:0] r_word, k_word;
  logic        r_ready, k_ready, r_done, k_done, busy;
  logic [31:0] res_word;

  int          checkCount = 0;
  int          errorCount = 0;
  bit          monitorOn = 1'b0;

  expEntry_t   rq[$];
  expEntry_t   kq[$];
  int          cyc = 0;
  int          busyEnd = -1;
  logic [31:0] lastRes = 32'd0;
  bit          fav = PRIO_INIT;

  sm4_tau_arbiter #(.PRIO_INIT(PRIO_INIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .r_valid  (r_valid),
    .r_word   (r_word),
    .r_ready  (r_ready),
    .r_done   (r_done),
    .k_valid  (k_valid),
    .k_word   (k_word),
    .k_ready  (k_ready),
    .k_done   (k_done),
    .res_word (res_word),
    .busy     (busy)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Reference tau: substitute each byte of the word independently.
  function automatic logic [31:0] tau(input logic [31:0] w);
    logic [31:0] t;
    for (int i = 0; i < 4; i++) t[31-8*i -: 8] = SM4_SBOX[w[31-8*i -: 8]];
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: the expected behaviour is rebuilt from the request rules.
  // A grant happens only when idle, lone requests win, contested ones go to
  // the favoured side, which then flips; results come 5 cycles after grant.
  always @(negedge clk) begin
    if (monitorOn) begin
      bit expIdle, expR, expK, expRD, expKD;
      cyc++;
      expIdle = !rst && (cyc > busyEnd);
      expR = expIdle && r_valid && (!k_valid || !fav);
      expK = expIdle && k_valid && (!r_valid ||  fav);
      checkOutput("r_ready", {31'd0, r_ready}, {31'd0, expR});
      checkOutput("k_ready", {31'd0, k_ready}, {31'd0, expK});
      checkOutput("busy", {31'd0, busy}, {31'd0, (cyc <= busyEnd)});
      expRD = (rq.size() > 0) && (rq[0].doneCyc == cyc);
      expKD = (kq.size() > 0) && (kq[0].doneCyc == cyc);
      checkOutput("r_done", {31'd0, r_done}, {31'd0, expRD});
      checkOutput("k_done", {31'd0, k_done}, {31'd0, expKD});
      if (expRD) begin
        checkOutput("r result", res_word, rq[0].res);
        lastRes = rq[0].res;
        void'(rq.pop_front());
      end else if (expKD) begin
        checkOutput("k result", res_word, kq[0].res);
        lastRes = kq[0].res;
        void'(kq.pop_front());
      end else begin
        checkOutput("res_word hold", res_word, lastRes);
      end
      if (expR) begin
        rq.push_back('{res: tau(r_word), doneCyc: cyc + 5});
        busyEnd = cyc + 5;
        fav = 1'b1;
      end
      if (expK) begin
        kq.push_back('{res: tau(k_word), doneCyc: cyc + 5});
        busyEnd = cyc + 5;
        fav = 1'b0;
      end
      if (rst) begin
        rq.delete();
        kq.delete();
        busyEnd = -1;
        lastRes = 32'd0;
        fav = PRIO_INIT;
      end
    end
  end

  // Present one request; hold until granted, or withdraw after holdMax cycles
  // when holdMax is non-zero. After a grant the word is replaced by afterWord.
  task automatic applyStimulus(input int id, input logic [31:0] w, input int holdMax,
                               input logic [31:0] afterWord);
    int n = 0;
    bit granted = 1'b0;
    @(posedge clk); #1;
    if (id == 0) begin r_valid = 1'b1; r_word = w; end
    else         begin k_valid = 1'b1; k_word = w; end
    while (!granted) begin
      @(negedge clk);
      if ((id == 0) ? r_ready : k_ready) granted = 1'b1;
      else begin
        n++;
        if (holdMax != 0 && n >= holdMax) break;
        if (n >= 60) begin
          checkCount++;
          errorCount++;
          $display("[TB] FAIL grant timeout: requester %0d waited %0d cycles, required grant within 60", id, n);
          break;
        end
      end
    end
    @(posedge clk); #1;
    if (id == 0) begin r_valid = 1'b0; if (granted) r_word = afterWord; end
    else         begin k_valid = 1'b0; if (granted) k_word = afterWord; end
  endtask

  // Directed known-answer check against the literal expected result.
  task automatic waitDone(input int id, input logic [31:0] exp, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if ((id == 0) ? r_done : k_done) begin
        seen = 1'b1;
        checkOutput(name, res_word, exp);
      end
    end
    if (!seen) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL %s: done pulse absent, required within 20 cycles", name);
    end
  endtask

  task automatic randDriver(input int id);
    for (int i = 0; i < 15; i++) begin
      int hold;
      repeat ($urandom_range(0, 6)) @(posedge clk);
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      applyStimulus(id, $urandom, hold, $urandom);
    end
  endtask

  initial begin
    rst = 1'b1;
    r_valid = 1'b0; k_valid = 1'b0;
    r_word = 32'd0; k_word = 32'd0;
    repeat (2) @(posedge clk);
    #1 monitorOn = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    $display("[TB] single round request");
    fork
      applyStimulus(0, 32'h00010203, 0, 32'hffffffff);
      waitDone(0, 32'hd690e9fe, "single r");
    join

    $display("[TB] single key request");
    fork
      applyStimulus(1, 32'hffab7110, 0, 32'h0);
      waitDone(1, 32'h48ab002b, "single k");
    join

    $display("[TB] contention");
    fork
      applyStimulus(0, 32'h0f1e2d3c, 0, 32'h0);
      applyStimulus(1, 32'h00010203, 0, 32'h0);
      waitDone(0, 32'h0506cf75, "contention r");
      waitDone(1, 32'hd690e9fe, "contention k");
    join

    $display("[TB] word change and withdrawn request");
    fork
      begin
        applyStimulus(0, 32'h00010203, 0, 32'hffffffff);
        applyStimulus(1, 32'h11223344, 1, 32'h0);
      end
      waitDone(0, 32'hd690e9fe, "word change");
    join

    $display("[TB] reset mid-operation");
    applyStimulus(0, 32'ha5a5a5a5, 0, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    fork
      applyStimulus(0, 32'h00010203, 0, 32'h0);
      applyStimulus(1, 32'hffab7110, 0, 32'h0);
      waitDone(0, 32'hd690e9fe, "after reset r");
      waitDone(1, 32'h48ab002b, "after reset k");
    join

    $display("[TB] random traffic");
    fork
      randDriver(0);
      randDriver(1);
    join

    repeat (12) @(negedge clk);
    checkOutput("scoreboard drained", rq.size() + kq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
